intersection_sequencer: RTL and testbench
=========================================

// Module: intersection_sequencer
// PURPOSE
//  Timed phase sequencer for the four-way intersection. Drives the 3-bit phase code consumed by the light decoder.
//  Phase codes: 0 NS green, 1 NS yellow, 2 all-red ped, 3 EW left, 4 EW green, 5 EW yellow, 6 all-red ped, 7 NS left.
//  Latches pedestrian and left-turn requests; serves requested phases only.
// PARAMETERS
//  TICK_DIV     50_000_000  clk cycles per timer tick (>=1)
//  TIMER_W      8           width of phase timer
//  GREEN_TICKS  20          dwell of phases 0,4 in ticks
//  YELLOW_TICKS 4           dwell of phases 1,5
//  PED_TICKS    10          dwell of phases 2,6
//  LEFT_TICKS   6           dwell of phases 3,7
// PORTS
//  clk          in   1        system clock
//  resetn       in   1        synchronous, active-low reset
//  en           in   1        1 = run; 0 = freeze prescaler, timer, phase
//  ped_btn      in   1        pedestrian button, level, sampled every clk
//  left_sense   in   2        [0] NS left-lane car, [1] EW left-lane car
//  fsm_state    out  3        current phase code (to light decoder)
//  phase_done   out  1        1-cycle pulse on the edge that changes phase
//  ped_pending  out  1        latched pedestrian request
//  left_pending out  2        latched left requests, bit map as left_sense
//  ticks_left   out  TIMER_W  remaining ticks in current phase
// BEHAVIOUR
//  Reset (resetn=0 at posedge): fsm_state=0, phase_done=0, ped_pending=0, left_pending=0,
//   ticks_left=GREEN_TICKS, prescaler=0. Reset has priority over en and all inputs.
//  Prescaler: counts 0..TICK_DIV-1 while en=1; tick=1 when count==TICK_DIV-1, then wraps to 0.
//   Prescaler reloads 0 on every phase change -> each phase lasts exactly DUR*TICK_DIV en-cycles.
//  Timer: on tick with ticks_left>1, decrement. On tick with ticks_left==1, advance phase on
//   that edge, load next phase's duration, assert phase_done for that one cycle.
//  Durations of 0 are treated as 1.
//  Transitions (taken only at timer expiry):
//   0->1; 4->5; 3->4; 7->0
//   1 -> 2 if P else (3 if L[1] else 4)
//   5 -> 6 if P else (7 if L[0] else 0)
//   2 -> 3 if L[1] else 4;  6 -> 7 if L[0] else 0
//   P = ped_pending|ped_btn; L = left_pending|left_sense, evaluated in the expiry cycle.
//  Request latches:
//   ped_pending sets when ped_btn=1, except in phases 2/6 (ignored). Cleared on the edge entering 2 or 6
//   (clear wins over a same-cycle press).
//   left_pending[i] sets when left_sense[i]=1, ignored while in its own left phase (3 for bit1, 7 for bit0).
//   Cleared on the edge entering that phase.
//  en=0: prescaler, ticks_left, fsm_state hold; phase_done=0; request latches still set.
//  fsm_state, ticks_left, phase_done, pending outputs are registered; no combinational input->output paths.
//  Never outputs a phase outside the table; illegal internal state recovers to 0 next cycle.
// TESTING (TICK_DIV=2, GREEN=4, YELLOW=2, PED=3, LEFT=2, en=1)
//  1 Reset release, no requests -> fsm_state 0 for 8 cycles, then 1 for 4, 4 for 8, 5 for 4, back to 0;
//    phase_done pulses once per change.
//  2 ped_btn 1-cycle pulse in phase 0 -> ped_pending=1; after 1 goes to 2 for 6 cycles, ped_pending=0
//    on entry, then 4.
//  3 left_sense=2'b10 pulse in phase 0 -> 1->3(4 cycles)->4; left_sense=2'b01 in phase 4 -> 5->7->0;
//    bits clear on entry.
//  4 ped_btn held high through phases 1..2 -> single ped phase 2, ped_pending=0 after it; 4 follows, no re-entry.
//  5 resetn=0 for one cycle mid phase 5 -> next cycle fsm_state=0, ticks_left=4, all pending=0.
//  6 en=0 for 10 cycles mid phase 4 -> fsm_state and ticks_left frozen; phase ends 10 cycles later than in test 1.

Source files
------------

// File: rtl/intersection_sequencer.sv
`default_nettype none
// ============================================================================
// Module : intersection_sequencer
// Brief  : Timed phase sequencer for a four-way intersection with latched
//          pedestrian and left-turn requests.
// Rev    : 1.0  initial release
// ============================================================================
module intersection_sequencer #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int TIMER_W      = 8,
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 4,
  parameter int PED_TICKS    = 10,
  parameter int LEFT_TICKS   = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               en,
  input  logic               ped_btn,
  input  logic [1:0]         left_sense,
  output logic [2:0]         fsm_state,
  output logic               phase_done,
  output logic               ped_pending,
  output logic [1:0]         left_pending,
  output logic [TIMER_W-1:0] ticks_left
);

  localparam logic [2:0] c_NS_GREEN  = 3'd0;
  localparam logic [2:0] c_NS_YELLOW = 3'd1;
  localparam logic [2:0] c_PED_A     = 3'd2;
  localparam logic [2:0] c_EW_LEFT   = 3'd3;
  localparam logic [2:0] c_EW_GREEN  = 3'd4;
  localparam logic [2:0] c_EW_YELLOW = 3'd5;
  localparam logic [2:0] c_PED_B     = 3'd6;
  localparam logic [2:0] c_NS_LEFT   = 3'd7;

  localparam int c_PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PS_W-1:0] c_PS_MAX = c_PS_W'((TICK_DIV > 1) ? TICK_DIV - 1 : 0);
  localparam logic [c_PS_W-1:0] c_PS_ONE = c_PS_W'(1);

  // Zero durations are clamped to one tick so every phase is visible.
  localparam logic [TIMER_W-1:0] c_ONE    = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] c_GREEN  = TIMER_W'((GREEN_TICKS  < 1) ? 1 : GREEN_TICKS);
  localparam logic [TIMER_W-1:0] c_YELLOW = TIMER_W'((YELLOW_TICKS < 1) ? 1 : YELLOW_TICKS);
  localparam logic [TIMER_W-1:0] c_PED    = TIMER_W'((PED_TICKS    < 1) ? 1 : PED_TICKS);
  localparam logic [TIMER_W-1:0] c_LEFT   = TIMER_W'((LEFT_TICKS   < 1) ? 1 : LEFT_TICKS);

  logic [2:0]         r_state;
  logic [TIMER_W-1:0] r_ticks;
  logic [c_PS_W-1:0]  r_presc;
  logic               r_done;
  logic               r_ped;
  logic [1:0]         r_left;

  logic               w_tick;
  logic               w_expire;
  logic               w_ped_req;
  logic [1:0]         w_left_req;
  logic [2:0]         w_next;
  logic [TIMER_W-1:0] w_ticks_nxt;
  logic [c_PS_W-1:0]  w_presc_nxt;
  logic               w_done_nxt;
  logic               w_ped_nxt;
  logic [1:0]         w_left_nxt;

  function automatic logic [TIMER_W-1:0] f_dur(input logic [2:0] ph);
    case (ph)
      c_NS_GREEN, c_EW_GREEN:   f_dur = c_GREEN;
      c_NS_YELLOW, c_EW_YELLOW: f_dur = c_YELLOW;
      c_PED_A, c_PED_B:         f_dur = c_PED;
      default:                  f_dur = c_LEFT;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= c_NS_GREEN;
      r_ticks <= c_GREEN;
      r_presc <= '0;
      r_done  <= 1'b0;
      r_ped   <= 1'b0;
      r_left  <= 2'b00;
    end else begin
      r_state <= w_expire ? w_next : r_state;
      r_ticks <= w_ticks_nxt;
      r_presc <= w_presc_nxt;
      r_done  <= w_done_nxt;
      r_ped   <= w_ped_nxt;
      r_left  <= w_left_nxt;
    end
  end

  // A timer value of 0 can only come from corruption; treat it as expiry.
  always_comb begin
    w_tick     = en && (r_presc == c_PS_MAX);
    w_expire   = w_tick && (r_ticks <= c_ONE);
    w_ped_req  = r_ped | ped_btn;
    w_left_req = r_left | left_sense;
    w_next     = c_NS_GREEN;
    case (r_state)
      c_NS_GREEN:  w_next = c_NS_YELLOW;
      c_NS_YELLOW: w_next = w_ped_req ? c_PED_A : (w_left_req[1] ? c_EW_LEFT : c_EW_GREEN);
      c_PED_A:     w_next = w_left_req[1] ? c_EW_LEFT : c_EW_GREEN;
      c_EW_LEFT:   w_next = c_EW_GREEN;
      c_EW_GREEN:  w_next = c_EW_YELLOW;
      c_EW_YELLOW: w_next = w_ped_req ? c_PED_B : (w_left_req[0] ? c_NS_LEFT : c_NS_GREEN);
      c_PED_B:     w_next = w_left_req[0] ? c_NS_LEFT : c_NS_GREEN;
      c_NS_LEFT:   w_next = c_NS_GREEN;
      default:     w_next = c_NS_GREEN;
    endcase
  end

  always_comb begin
    w_presc_nxt = r_presc;
    w_ticks_nxt = r_ticks;
    w_done_nxt  = 1'b0;
    if (w_tick) begin
      w_presc_nxt = '0;
      if (w_expire) begin
        w_ticks_nxt = f_dur(w_next);
        w_done_nxt  = 1'b1;
      end else begin
        w_ticks_nxt = r_ticks - c_ONE;
      end
    end else if (en) begin
      w_presc_nxt = r_presc + c_PS_ONE;
    end

    // Clearing on phase entry takes priority over a press in the same cycle.
    w_ped_nxt = r_ped;
    if (w_expire && (w_next == c_PED_A || w_next == c_PED_B))
      w_ped_nxt = 1'b0;
    else if (ped_btn && r_state != c_PED_A && r_state != c_PED_B)
      w_ped_nxt = 1'b1;

    w_left_nxt = r_left;
    if (w_expire && w_next == c_EW_LEFT)
      w_left_nxt[1] = 1'b0;
    else if (left_sense[1] && r_state != c_EW_LEFT)
      w_left_nxt[1] = 1'b1;
    if (w_expire && w_next == c_NS_LEFT)
      w_left_nxt[0] = 1'b0;
    else if (left_sense[0] && r_state != c_NS_LEFT)
      w_left_nxt[0] = 1'b1;
  end

  assign fsm_state    = r_state;
  assign phase_done   = r_done;
  assign ped_pending  = r_ped;
  assign left_pending = r_left;
  assign ticks_left   = r_ticks;

endmodule
`default_nettype wire

// File: tb/tb_intersection_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_intersection_sequencer
// Brief  : Phase-sequence scoreboard bench for intersection_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_intersection_sequencer;

  localparam int c_DIV = 2;
  localparam int c_TW  = 8;
  localparam int c_G   = 4;
  localparam int c_Y   = 2;
  localparam int c_P   = 3;
  localparam int c_L   = 2;

  typedef struct {
    logic [2:0] code;
    int         cycles;
  } exp_t;

  logic            clk = 1'b0;
  logic            resetn;
  logic            en;
  logic            ped_btn;
  logic [1:0]      left_sense;
  logic [2:0]      fsm_state;
  logic            phase_done;
  logic            ped_pending;
  logic [1:0]      left_pending;
  logic [c_TW-1:0] ticks_left;

  int         n_checks = 0;
  int         n_fail   = 0;
  exp_t       sb[$];
  logic       mon_en   = 1'b0;
  logic [2:0] prev_state;
  int         ph_cnt;

  intersection_sequencer #(
    .TICK_DIV(c_DIV), .TIMER_W(c_TW), .GREEN_TICKS(c_G),
    .YELLOW_TICKS(c_Y), .PED_TICKS(c_P), .LEFT_TICKS(c_L)
  ) dut (
    .clk(clk), .resetn(resetn), .en(en), .ped_btn(ped_btn),
    .left_sense(left_sense), .fsm_state(fsm_state), .phase_done(phase_done),
    .ped_pending(ped_pending), .left_pending(left_pending), .ticks_left(ticks_left)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [2:0] code, input int cycles);
    exp_t e;
    e.code   = code;
    e.cycles = cycles;
    sb.push_back(e);
  endtask

  // Advances at least one cycle, then waits (bounded) for the given phase.
  task automatic wait_state(input logic [2:0] code);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (fsm_state != code && n < 200);
    check_eq("wait_state", fsm_state, code);
  endtask

  // Measures every phase and compares it against the expected sequence.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en) begin
      if (fsm_state != prev_state) begin
        check_eq("done_pulse", phase_done, 1);
        if (sb.size() == 0) begin
          check_eq("sb_unexpected_phase", prev_state, 3'd0 - 3'd1 - prev_state);
        end else begin
          e = sb.pop_front();
          check_eq("phase_code", prev_state, e.code);
          check_eq("phase_len", ph_cnt, e.cycles);
        end
        prev_state = fsm_state;
        ph_cnt     = 1;
      end else begin
        check_eq("done_idle", phase_done, 0);
        ph_cnt++;
      end
    end
  end

  initial begin
    resetn = 1'b0; en = 1'b1; ped_btn = 1'b0; left_sense = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state", fsm_state, 0);
    check_eq("rst_ticks", ticks_left, c_G);
    check_eq("rst_done", phase_done, 0);
    check_eq("rst_ped", ped_pending, 0);
    check_eq("rst_left", left_pending, 0);

    // Plain cycle without requests
    push_exp(3'd0, c_G*c_DIV); push_exp(3'd1, c_Y*c_DIV);
    push_exp(3'd4, c_G*c_DIV); push_exp(3'd5, c_Y*c_DIV);
    @(negedge clk);
    resetn = 1'b1; prev_state = 3'd0; ph_cnt = 1; mon_en = 1'b1;
    wait_state(3'd5);
    wait_state(3'd0);

    // Pedestrian pulse in phase 0
    push_exp(3'd0, c_G*c_DIV); push_exp(3'd1, c_Y*c_DIV); push_exp(3'd2, c_P*c_DIV);
    push_exp(3'd4, c_G*c_DIV); push_exp(3'd5, c_Y*c_DIV);
    @(negedge clk); ped_btn = 1'b1;
    @(posedge clk); #1;
    check_eq("ped_latch", ped_pending, 1);
    @(negedge clk); ped_btn = 1'b0;
    wait_state(3'd2);
    check_eq("ped_clr", ped_pending, 0);
    wait_state(3'd4);
    wait_state(3'd0);

    // Left-turn requests on both approaches
    push_exp(3'd0, c_G*c_DIV); push_exp(3'd1, c_Y*c_DIV); push_exp(3'd3, c_L*c_DIV);
    push_exp(3'd4, c_G*c_DIV); push_exp(3'd5, c_Y*c_DIV); push_exp(3'd7, c_L*c_DIV);
    @(negedge clk); left_sense = 2'b10;
    @(posedge clk); #1;
    check_eq("left1_latch", left_pending, 2'b10);
    @(negedge clk); left_sense = 2'b00;
    wait_state(3'd3);
    check_eq("left1_clr", left_pending, 2'b00);
    wait_state(3'd4);
    @(negedge clk); left_sense = 2'b01;
    @(posedge clk); #1;
    check_eq("left0_latch", left_pending, 2'b01);
    @(negedge clk); left_sense = 2'b00;
    wait_state(3'd7);
    check_eq("left0_clr", left_pending, 2'b00);
    wait_state(3'd0);

    // Button held through phases 1..2 gives exactly one ped phase
    push_exp(3'd0, c_G*c_DIV); push_exp(3'd1, c_Y*c_DIV); push_exp(3'd2, c_P*c_DIV);
    push_exp(3'd4, c_G*c_DIV); push_exp(3'd5, c_Y*c_DIV);
    wait_state(3'd1);
    @(negedge clk); ped_btn = 1'b1;
    wait_state(3'd2);
    check_eq("ped_hold_clr", ped_pending, 0);
    @(posedge clk); #1;
    check_eq("ped_ignored_in_2", ped_pending, 0);
    @(negedge clk); ped_btn = 1'b0;
    wait_state(3'd4);
    check_eq("ped_after_2", ped_pending, 0);
    wait_state(3'd0);
    check_eq("ped_no_reentry", ped_pending, 0);

    // Freeze for 10 cycles in phase 4
    push_exp(3'd0, c_G*c_DIV); push_exp(3'd1, c_Y*c_DIV);
    push_exp(3'd4, c_G*c_DIV + 10); push_exp(3'd5, c_Y*c_DIV);
    wait_state(3'd4);
    repeat (3) begin @(posedge clk); #1; end
    check_eq("ticks_run", ticks_left, c_G - 1);
    @(negedge clk); en = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      check_eq("frz_state", fsm_state, 4);
      check_eq("frz_ticks", ticks_left, c_G - 1);
    end
    @(negedge clk); en = 1'b1;
    wait_state(3'd0);

    // Reset in the middle of phase 5 with requests pending
    push_exp(3'd0, c_G*c_DIV); push_exp(3'd1, c_Y*c_DIV); push_exp(3'd4, c_G*c_DIV);
    wait_state(3'd5);
    @(negedge clk); ped_btn = 1'b1; left_sense = 2'b11;
    @(posedge clk); #1;
    check_eq("pre_rst_ped", ped_pending, 1);
    check_eq("pre_rst_left", left_pending, 2'b11);
    @(negedge clk); ped_btn = 1'b0; left_sense = 2'b00; resetn = 1'b0; mon_en = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_state", fsm_state, 0);
    check_eq("mid_rst_ticks", ticks_left, c_G);
    check_eq("mid_rst_ped", ped_pending, 0);
    check_eq("mid_rst_left", left_pending, 0);
    check_eq("mid_rst_done", phase_done, 0);
    check_eq("sb_pre_rst", sb.size(), 0);
    @(negedge clk);
    resetn = 1'b1; prev_state = 3'd0; ph_cnt = 1;
    push_exp(3'd0, c_G*c_DIV);
    mon_en = 1'b1;
    wait_state(3'd1);
    repeat (2) @(posedge clk);
    #2;
    check_eq("sb_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
